// File: rtl/imem_loader_if.sv
// Stream-in / imem-write-out bundle for the boot-time instruction memory loader.
// The slave modport is the loader side; the master modport is the stream source and memory observer.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 32
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_enable;
  logic              done;
  logic              error;

  modport master (
    output in_data, in_valid,
    input  in_ready, imem_we, imem_addr, imem_wdata, cpu_enable, done, error
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, imem_we, imem_addr, imem_wdata, cpu_enable, done, error
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: byte stream -> little-endian 32-bit words written to imem, then releases the CPU.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       MAX_WORDS = 256
) (
  input  logic           clk,
  input  logic           reset,
  imem_loader_if.slave   bus
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [2:0] {
    S_HDR0,
    S_HDR1,
    S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_WAIT,
    S_DONE,
    S_ERR
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    n_q, n_d;
  logic [CNT_W-1:0]    widx_q, widx_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [WORD_W-1:0]   asm_q, asm_d;
  logic                in_ready_q, in_ready_d;
  logic                imem_we_q, imem_we_d;
  logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
  logic [WORD_W-1:0]   imem_wdata_q, imem_wdata_d;
  logic                cpu_enable_q, cpu_enable_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]          csum_q, csum_d;
`endif

  logic                xfer_c;
  logic [CNT_W-1:0]    n_full_c;
  logic [WORD_W-1:0]   asm_lane_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_HDR0;
      n_q          <= '0;
      widx_q       <= '0;
      byte_cnt_q   <= '0;
      asm_q        <= '0;
      in_ready_q   <= 1'b1;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= BASE_ADDR;
      imem_wdata_q <= '0;
      cpu_enable_q <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      widx_q       <= widx_d;
      byte_cnt_q   <= byte_cnt_d;
      asm_q        <= asm_d;
      in_ready_q   <= in_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_enable_q <= cpu_enable_d;
      done_q       <= done_d;
      error_q      <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  // Next-state and datapath; in_ready follows the next state so it is exact per state.
  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    widx_d       = widx_q;
    byte_cnt_d   = byte_cnt_q;
    asm_d        = asm_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d       = csum_q;
`endif

    xfer_c     = bus.in_valid && in_ready_q;
    n_full_c   = {bus.in_data, n_q[7:0]};
    asm_lane_c = asm_q;
    asm_lane_c[{byte_cnt_q, 3'b000} +: 8] = bus.in_data;

    case (state_q)
      S_HDR0: begin
        if (xfer_c) begin
          n_d     = CNT_W'(bus.in_data);
          state_d = S_HDR1;
        end
      end
      S_HDR1: begin
        if (xfer_c) begin
          n_d = n_full_c;
          if (n_full_c == '0)                      state_d = S_DONE;
          else if (32'(n_full_c) > MAX_WORDS)      state_d = S_ERR;
          else                                     state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer_c) begin
          asm_d      = asm_lane_c;
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d     = csum_q ^ bus.in_data;
`endif
          if (byte_cnt_q == 2'd3) begin
            imem_we_d    = 1'b1;
            imem_wdata_d = asm_lane_c;
            imem_addr_d  = BASE_ADDR + ADDR_W'({widx_q, 2'b00});
            widx_d       = widx_q + 16'd1;
            asm_d        = '0;
            if (widx_q == n_q - 16'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_d = S_CSUM;
`else
              state_d = S_WAIT;
`endif
            end
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (xfer_c) state_d = (bus.in_data == csum_q) ? S_WAIT : S_ERR;
      end
`endif
      S_WAIT:  state_d = S_DONE;
      S_DONE:  state_d = S_DONE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_HDR0;
    endcase

    in_ready_d = (state_d == S_HDR0) || (state_d == S_HDR1) || (state_d == S_DATA)
`ifdef IMEM_LOADER_CHECKSUM_EN
               || (state_d == S_CSUM)
`endif
               ;

    // Status flags lag the state by one register stage.
    done_d       = (state_q == S_DONE);
    cpu_enable_d = (state_q == S_DONE);
    error_d      = (state_q == S_ERR);
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign bus.cpu_enable = cpu_enable_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;

endmodule
